dodge_game_ctrl: RTL and testbench
==================================

Name: dodge_game_ctrl

Overview:
Game-level sequencer for the 8-column dodge game. It drives the player shifter's active-low init and its left/right move requests, and generates one falling obstacle. It detects collisions against the shifter's one-cold player position and keeps score. It sits between the button synchronisers and the player shifter / LED-matrix renderer.

Parameters:
TICK_DIV, 7142857, CLK cycles per game tick (50 MHz -> 7 Hz, matches the shifter step rate)
FALL_TICKS, 4, game ticks per obstacle row step
SCORE_W, 8, score counter width

Ports:
CLK  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  synchronised start button, level
left_btn  input  1  synchronised left button, level
right_btn  input  1  synchronised right button, level
player_pos  input  8  shifter output, one-cold (0 bit = player column)
shifter_init  output  1  active-low init to player shifter
move_left  output  1  gated left request to shifter
move_right  output  1  gated right request to shifter
obs_row  output  8  one-hot obstacle column, 0 when none
obs_y  output  3  obstacle row, 0 = top, 7 = player row
score  output  SCORE_W  obstacles dodged
game_over  output  1  high in OVER
ready  output  1  high when IDLE dwell is complete and start is accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; score=0; obs_row=0; obs_y=0; lfsr=8'hA5.
  - dwell counter=0; tick and fall counters=0.
  - shifter_init=0; move_left=move_right=0; game_over=0; ready=0.
  - Reset mid-game aborts immediately, with no partial score update.
- LFSR:
  - 8-bit, free-running every CLK whenever out of reset.
  - Shift left; bit0 <= b7^b5^b4^b3.
  - Spawn column = one-hot of lfsr[2:0], sampled at spawn time.
- start is rising-edge detected with a registered previous value. Edge pulse = start & ~start_q.
- States:
  - IDLE:
    - shifter_init=0; obs_row=0.
    - Dwell counter counts to TICK_DIV so the shifter sees init low on at least one of its own edges; then ready=1.
    - Start edge with ready=1 -> PLAY next cycle. Start edge with ready=0 is ignored.
    - On entry to PLAY: score=0; obs_y=0; obs_row=onehot(lfsr[2:0]); tick and fall counters=0.
  - PLAY:
    - shifter_init=1.
    - move_left = left_btn & ~right_btn; move_right = right_btn & ~left_btn. Both pressed -> both 0.
    - Tick counter wraps at TICK_DIV-1 and emits a 1-cycle tick. The fall counter counts ticks and emits a step on the FALL_TICKS-th tick.
    - Collision is evaluated every CLK: obs_y==7 and (obs_row & ~player_pos)!=0 -> OVER next cycle.
    - Step with obs_y<7: obs_y+1.
    - Step with obs_y==7 and no collision: score+1, saturating at 2^SCORE_W-1; respawn with obs_y=0 and obs_row=onehot(lfsr[2:0]).
    - Collision and step in the same cycle -> collision wins; score is unchanged.
    - start is ignored in PLAY.
  - OVER:
    - game_over=1; move_left=move_right=0; shifter_init=1, so the player is frozen in place.
    - obs_row, obs_y and score are held for display.
    - Start edge -> IDLE, and the dwell counter restarts.
- Tick and fall counters are held at 0 outside PLAY.
- All outputs are registered, except move_left/move_right (combinational from state and buttons). Latency from button to shifter request is 0 CLK.

Decomposition:
- Shared package dodge_pkg:
  - state enum (IDLE=2'd0, PLAY=2'd1, OVER=2'd2);
  - LFSR_SEED=8'hA5;
  - LFSR tap constant;
  - PLAYER_ROW=3'd7.
- One sub-module, tick_div: parameterised divider with enable, sync clear and a 1-cycle tick output. Instanced once for game ticks; the dwell counter reuses it when not in PLAY, or is a second instance.

Test Plan (TICK_DIV=4, FALL_TICKS=2, SCORE_W=2):
- Release reset, pulse start at cycle 1 -> ignored, ready=0. Pulse start after cycle 4 (ready=1) -> PLAY next cycle, shifter_init=1, obs_y=0, popcount(obs_row)=1.
- PLAY with player_pos bit at the obstacle column =1 (no overlap) -> obs_y advances every 8 cycles. Step at row 7 gives score=1, obs_y=0, and a new one-hot obs_row.
- At obs_y==7, drive player_pos=~obs_row -> OVER next cycle, game_over=1, score held, move_left=move_right=0 despite left_btn=1.
- Force collision in the same cycle as a step at row 7 -> OVER, score unchanged.
- left_btn=right_btn=1 in PLAY -> both moves 0. left_btn only -> move_left=1. Four dodges -> score saturates at 3.
- Assert rst_n=0 mid-PLAY between clock edges -> all outputs at reset values before the next CLK edge. Start from OVER -> IDLE, ready=0 for 4 cycles.

Source files
------------

// File: rtl/dodge_pkg.sv
// Shared types and constants for the dodge game controller.
package dodge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam logic [7:0] LFSR_SEED  = 8'hA5;
    // Feedback taps b7, b5, b4, b3 folded into one XOR-reduce mask
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam logic [2:0] PLAYER_ROW = 3'd7;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] col_onehot(input logic [2:0] c);
        return 8'd1 << c;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Divide-by-DIV counter with enable and sync clear; tick is high for the
// single cycle in which the counter wraps.
module tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dodge_game_ctrl.sv
// Game sequencer: drives the player shifter, drops one obstacle at a time,
// detects collisions against the one-cold player position and keeps score.
module dodge_game_ctrl
    import dodge_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 7142857,
    parameter int unsigned FALL_TICKS = 4,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               start,
    input  logic               left_btn,
    input  logic               right_btn,
    input  logic [7:0]         player_pos,
    output logic               shifter_init,
    output logic               move_left,
    output logic               move_right,
    output logic [7:0]         obs_row,
    output logic [2:0]         obs_y,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               ready
);

    localparam int unsigned   FW        = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [FW-1:0] FALL_LAST = FW'(FALL_TICKS - 1);

    state_e             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               start_q;
    logic               ready_q, ready_d;
    logic [7:0]         obs_row_q, obs_row_d;
    logic [2:0]         obs_y_q, obs_y_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [FW-1:0]      fall_q, fall_d;
    logic               shifter_init_q, shifter_init_d;
    logic               game_over_q, game_over_d;

    logic start_edge;
    logic collide;
    logic step;
    logic game_tick;
    logic dwell_tick;

    // Game tick counter is cleared by the next state so it already reads 0
    // in the first cycle after leaving PLAY.
    tick_div #(.DIV(TICK_DIV)) u_game_tick (
        .clk   (CLK),
        .rst_n (rst_n),
        .en    (state_q == PLAY),
        .clr   (state_d != PLAY),
        .tick  (game_tick)
    );

    tick_div #(.DIV(TICK_DIV)) u_dwell (
        .clk   (CLK),
        .rst_n (rst_n),
        .en    ((state_q == IDLE) && !ready_q),
        .clr   (state_q != IDLE),
        .tick  (dwell_tick)
    );

    always_comb begin
        state_d    = state_q;
        start_edge = start & ~start_q;
        collide    = (obs_y_q == PLAYER_ROW) && ((obs_row_q & ~player_pos) != '0);
        move_left  = 1'b0;
        move_right = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge && ready_q) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                move_left  = left_btn & ~right_btn;
                move_right = right_btn & ~left_btn;
                if (collide) begin
                    state_d = OVER;
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d    = lfsr_next(lfsr_q);
        obs_row_d = obs_row_q;
        obs_y_d   = obs_y_q;
        score_d   = score_q;
        fall_d    = fall_q;
        step      = game_tick && (fall_q == FALL_LAST);
        case (state_q)
            IDLE: begin
                obs_row_d = '0;
                if (state_d == PLAY) begin
                    score_d   = '0;
                    obs_y_d   = '0;
                    obs_row_d = col_onehot(lfsr_q[2:0]);
                end
            end
            PLAY: begin
                if (game_tick) begin
                    fall_d = (fall_q == FALL_LAST) ? '0 : fall_q + FW'(1);
                end
                // A collision freezes the board, even on a step cycle.
                if (!collide && step) begin
                    if (obs_y_q != PLAYER_ROW) begin
                        obs_y_d = obs_y_q + 3'd1;
                    end else begin
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        obs_y_d   = '0;
                        obs_row_d = col_onehot(lfsr_q[2:0]);
                    end
                end
            end
            OVER: begin
                if (state_d == IDLE) begin
                    obs_row_d = '0;
                end
            end
            default: ;
        endcase
        if (state_d != PLAY) begin
            fall_d = '0;
        end
        ready_d        = (state_d == IDLE) && (ready_q || dwell_tick);
        shifter_init_d = (state_d != IDLE);
        game_over_d    = (state_d == OVER);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            lfsr_q         <= LFSR_SEED;
            start_q        <= 1'b0;
            ready_q        <= 1'b0;
            obs_row_q      <= '0;
            obs_y_q        <= '0;
            score_q        <= '0;
            fall_q         <= '0;
            shifter_init_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            start_q        <= start;
            ready_q        <= ready_d;
            obs_row_q      <= obs_row_d;
            obs_y_q        <= obs_y_d;
            score_q        <= score_d;
            fall_q         <= fall_d;
            shifter_init_q <= shifter_init_d;
            game_over_q    <= game_over_d;
        end
    end

    assign shifter_init = shifter_init_q;
    assign obs_row      = obs_row_q;
    assign obs_y        = obs_y_q;
    assign score        = score_q;
    assign game_over    = game_over_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_dodge_game_ctrl.sv
// Directed bench for dodge_game_ctrl with a short tick (TICK_DIV=4, FALL_TICKS=2,
// SCORE_W=2): one obstacle row step every 8 cycles, a full fall every 64.
module tb_dodge_game_ctrl;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       left_btn = 1'b0;
    logic       right_btn = 1'b0;
    logic [7:0] player_pos = 8'hFE;
    logic       shifter_init, move_left, move_right, game_over, ready;
    logic [7:0] obs_row;
    logic [2:0] obs_y;
    logic [1:0] score;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_prev = 8'hA5;
    logic [7:0] obs_exp = 8'h00;

    dodge_game_ctrl #(.TICK_DIV(4), .FALL_TICKS(2), .SCORE_W(2)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .start        (start),
        .left_btn     (left_btn),
        .right_btn    (right_btn),
        .player_pos   (player_pos),
        .shifter_init (shifter_init),
        .move_left    (move_left),
        .move_right   (move_right),
        .obs_row      (obs_row),
        .obs_y        (obs_y),
        .score        (score),
        .game_over    (game_over),
        .ready        (ready)
    );

    always #5 CLK = ~CLK;

    // Reference LFSR; m_prev holds the value the DUT saw before the latest edge.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++; if ({shifter_init, move_left, move_right, obs_row, obs_y, score, game_over, ready} !== 17'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {shifter_init, move_left, move_right, obs_row, obs_y, score, game_over, ready}); end
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_start_gate();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        total++; if (shifter_init !== 1'b0) begin bad++; $display("FAIL early_start_init: got %b want 0", shifter_init); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL early_ready2: got %b want 0", ready); end
        @(negedge CLK);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL early_ready3: got %b want 0", ready); end
        @(negedge CLK);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_dwell: got %b want 1", ready); end
    endtask

    task automatic test_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        obs_exp = 8'd1 << m_prev[2:0];
        total++; if (shifter_init !== 1'b1) begin bad++; $display("FAIL play_init: got %b want 1", shifter_init); end
        total++; if (obs_y !== 3'd0) begin bad++; $display("FAIL play_obs_y: got %0d want 0", obs_y); end
        total++; if (score !== 2'd0) begin bad++; $display("FAIL play_score: got %0d want 0", score); end
        total++; if (obs_row !== obs_exp) begin bad++; $display("FAIL play_obs_row: got %h want %h", obs_row, obs_exp); end
        total++; if ({ready, game_over} !== 2'b00) begin bad++; $display("FAIL play_flags: got %b want 00", {ready, game_over}); end
    endtask

    task automatic play_dodge(input logic [1:0] exp_score);
        player_pos = ~{obs_exp[6:0], obs_exp[7]};
        repeat (64) @(negedge CLK);
        obs_exp = 8'd1 << m_prev[2:0];
        total++; if (score !== exp_score) begin bad++; $display("FAIL dodge_score: got %0d want %0d", score, exp_score); end
        total++; if (obs_y !== 3'd0) begin bad++; $display("FAIL dodge_obs_y: got %0d want 0", obs_y); end
        total++; if (obs_row !== obs_exp) begin bad++; $display("FAIL dodge_obs_row: got %h want %h", obs_row, obs_exp); end
    endtask

    task automatic test_fall();
        player_pos = ~{obs_exp[6:0], obs_exp[7]};
        for (int k = 1; k <= 7; k++) begin
            repeat (7) @(negedge CLK);
            total++; if (obs_y !== 3'(k - 1)) begin bad++; $display("FAIL fall_hold: got %0d want %0d", obs_y, k - 1); end
            @(negedge CLK);
            total++; if (obs_y !== 3'(k)) begin bad++; $display("FAIL fall_step: got %0d want %0d", obs_y, k); end
        end
        repeat (8) @(negedge CLK);
        obs_exp = 8'd1 << m_prev[2:0];
        total++; if (score !== 2'd1) begin bad++; $display("FAIL fall_score: got %0d want 1", score); end
        total++; if (obs_y !== 3'd0) begin bad++; $display("FAIL fall_respawn_y: got %0d want 0", obs_y); end
        total++; if (obs_row !== obs_exp) begin bad++; $display("FAIL fall_respawn_row: got %h want %h", obs_row, obs_exp); end
    endtask

    task automatic test_moves();
        left_btn = 1'b1; right_btn = 1'b1; #1;
        total++; if ({move_left, move_right} !== 2'b00) begin bad++; $display("FAIL move_both: got %b want 00", {move_left, move_right}); end
        right_btn = 1'b0; #1;
        total++; if ({move_left, move_right} !== 2'b10) begin bad++; $display("FAIL move_left: got %b want 10", {move_left, move_right}); end
        left_btn = 1'b0; right_btn = 1'b1; #1;
        total++; if ({move_left, move_right} !== 2'b01) begin bad++; $display("FAIL move_right: got %b want 01", {move_left, move_right}); end
        right_btn = 1'b0;
    endtask

    task automatic test_collision();
        player_pos = ~{obs_exp[6:0], obs_exp[7]};
        repeat (56) @(negedge CLK);
        total++; if (obs_y !== 3'd7) begin bad++; $display("FAIL coll_row7: got %0d want 7", obs_y); end
        player_pos = ~obs_exp;
        left_btn = 1'b1;
        @(negedge CLK);
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL coll_over: got %b want 1", game_over); end
        total++; if (score !== 2'd1) begin bad++; $display("FAIL coll_score: got %0d want 1", score); end
        total++; if ({move_left, move_right} !== 2'b00) begin bad++; $display("FAIL coll_moves: got %b want 00", {move_left, move_right}); end
        total++; if (shifter_init !== 1'b1) begin bad++; $display("FAIL coll_init: got %b want 1", shifter_init); end
        repeat (10) @(negedge CLK);
        total++; if ({obs_row, obs_y, score} !== {obs_exp, 3'd7, 2'd1}) begin bad++; $display("FAIL over_hold: got %h want %h", {obs_row, obs_y, score}, {obs_exp, 3'd7, 2'd1}); end
        left_btn = 1'b0;
    endtask

    task automatic test_restart();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        total++; if ({game_over, shifter_init, obs_row} !== 10'h0) begin bad++; $display("FAIL restart_idle: got %h want 0", {game_over, shifter_init, obs_row}); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL restart_dwell%0d: got %b want 0", i, ready); end
            @(negedge CLK);
        end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL restart_ready: got %b want 1", ready); end
        test_start();
    endtask

    task automatic test_back_to_back();
        test_restart();
        play_dodge(2'd1);
        player_pos = ~{obs_exp[6:0], obs_exp[7]};
        repeat (63) @(negedge CLK);
        total++; if (obs_y !== 3'd7) begin bad++; $display("FAIL b2b_row7: got %0d want 7", obs_y); end
        player_pos = ~obs_exp;
        @(negedge CLK);
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL b2b_over: got %b want 1", game_over); end
        total++; if ({obs_row, obs_y, score} !== {obs_exp, 3'd7, 2'd1}) begin bad++; $display("FAIL b2b_hold: got %h want %h", {obs_row, obs_y, score}, {obs_exp, 3'd7, 2'd1}); end
    endtask

    task automatic test_saturate();
        test_restart();
        play_dodge(2'd1);
        play_dodge(2'd2);
        play_dodge(2'd3);
        play_dodge(2'd3);
    endtask

    task automatic test_async_reset();
        player_pos = ~{obs_exp[6:0], obs_exp[7]};
        repeat (20) @(negedge CLK);
        left_btn = 1'b1;
        #1;
        total++; if (move_left !== 1'b1) begin bad++; $display("FAIL pre_reset_move: got %b want 1", move_left); end
        #1 rst_n = 1'b0;
        #1;
        total++; if ({shifter_init, move_left, move_right, obs_row, obs_y, score, game_over, ready} !== 17'h0) begin bad++; $display("FAIL async_reset: got %h want 0", {shifter_init, move_left, move_right, obs_row, obs_y, score, game_over, ready}); end
        left_btn = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start_gate();
        test_start();
        test_fall();
        test_moves();
        test_collision();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
